// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the RV32I execute-stage ALU:
//   - operation class codes carried in S[1:0]
//   - funct3 codes carried in S[4:2]
//   - the complete 6-bit pre-packed select words {funct7[5], funct3, class}
// ---------------------------------------------------------------------------
package alu_pkg;

  // Operation class in S[1:0]
  localparam logic [1:0] CLS_ALU = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b11;

  // funct3 codes for register/immediate ALU ops
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct3 codes for branch compares
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Full select words
  localparam logic [5:0] S_ADD  = 6'd1;
  localparam logic [5:0] S_SUB  = 6'd33;
  localparam logic [5:0] S_SLL  = 6'd5;
  localparam logic [5:0] S_SLT  = 6'd9;
  localparam logic [5:0] S_SLTU = 6'd13;
  localparam logic [5:0] S_XOR  = 6'd17;
  localparam logic [5:0] S_SRL  = 6'd21;
  localparam logic [5:0] S_SRA  = 6'd53;
  localparam logic [5:0] S_OR   = 6'd25;
  localparam logic [5:0] S_AND  = 6'd29;
  localparam logic [5:0] S_BEQ  = 6'd3;
  localparam logic [5:0] S_BNE  = 6'd7;
  localparam logic [5:0] S_BLT  = 6'd19;
  localparam logic [5:0] S_BGE  = 6'd23;
  localparam logic [5:0] S_BLTU = 6'd27;
  localparam logic [5:0] S_BGEU = 6'd31;

endpackage

// File: rtl/riscv_alu_cmp.sv
// ---------------------------------------------------------------------------
// riscv_alu_cmp
//   Operand comparator shared by SLT/SLTU and the branch-condition decode.
//   Ports:
//     a, b         operands
//     eq           a == b
//     lt_signed    a <  b, two's-complement
//     lt_unsigned  a <  b, unsigned
// ---------------------------------------------------------------------------
module riscv_alu_cmp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt_signed,
  output logic             lt_unsigned
);

  assign eq          = (a == b);
  assign lt_unsigned = (a < b);
  assign lt_signed   = ($signed(a) < $signed(b));

endmodule

// File: rtl/riscv_alu.sv
// ---------------------------------------------------------------------------
// riscv_alu
//   32-bit integer ALU for the RV32I execute stage.
//   Ports:
//     clk, rst_n  clock / async active-low reset (only used when REG_OUT=1)
//     A, B        operands (rs1, rs2-or-immediate)
//     S           select {funct7[5], funct3[2:0], class[1:0]}
//     Q           arithmetic/logic/shift/set-less-than result (class 01)
//     CMP         branch condition (class 11)
//   REG_OUT=0 gives a purely combinational path; REG_OUT=1 registers Q and
//   CMP with one cycle of latency.
// ---------------------------------------------------------------------------
module riscv_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       S,
  output logic [WIDTH-1:0] Q,
  output logic             CMP
);

  logic [1:0]       op_class;
  logic [2:0]       funct3;
  logic             alt;      // funct7[5]: selects SUB / SRA
  logic [4:0]       shamt;    // upper bits of B never affect a shift
  logic             eq, lt_signed, lt_unsigned;
  logic [WIDTH-1:0] q_d;
  logic             cmp_d;

  assign op_class = S[1:0];
  assign funct3   = S[4:2];
  assign alt      = S[5];
  assign shamt    = B[4:0];

  riscv_alu_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a           (A),
    .b           (B),
    .eq          (eq),
    .lt_signed   (lt_signed),
    .lt_unsigned (lt_unsigned)
  );

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    q_d   = '0;
    cmp_d = 1'b0;

    if (op_class == CLS_ALU) begin
      case (funct3)
        F3_ADD_SUB: q_d = alt ? (A - B) : (A + B);
        F3_SR:      q_d = alt ? WIDTH'($signed(A) >>> shamt) : (A >> shamt);
        // Only ADD/SUB and SRL/SRA have an alternate form; any other
        // funct3 with funct7[5] set is undefined and yields zero.
        F3_SLL:     if (!alt) q_d = A << shamt;
        // Set-less-than includes equality by project decision.
        F3_SLT:     if (!alt) q_d = {{(WIDTH-1){1'b0}}, lt_signed | eq};
        F3_SLTU:    if (!alt) q_d = {{(WIDTH-1){1'b0}}, lt_unsigned | eq};
        F3_XOR:     if (!alt) q_d = A ^ B;
        F3_OR:      if (!alt) q_d = A | B;
        F3_AND:     if (!alt) q_d = A & B;
        default:    q_d = '0;
      endcase
    end

    if (op_class == CLS_BR) begin
      case (funct3)
        F3_BEQ:  cmp_d = eq;
        F3_BNE:  cmp_d = !eq;
        F3_BLT:  cmp_d = lt_signed;
        F3_BGE:  cmp_d = !lt_signed;
        F3_BLTU: cmp_d = lt_unsigned;
        F3_BGEU: cmp_d = !lt_unsigned;
        default: cmp_d = 1'b0;
      endcase
    end
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] q_q;
    logic             cmp_q;

    // NOTE: state updates use non-blocking assignments so every flop
    // samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_q   <= '0;
        cmp_q <= 1'b0;
      end else begin
        q_q   <= q_d;
        cmp_q <= cmp_d;
      end
    end

    assign Q   = q_q;
    assign CMP = cmp_q;
  end else begin : g_comb
    // Clock and reset have no load in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};

    assign Q   = q_d;
    assign CMP = cmp_d;
  end

endmodule

// File: tb/tb_riscv_alu.sv
// ---------------------------------------------------------------------------
// tb_riscv_alu
//   Drives a combinational (REG_OUT=0) and a registered (REG_OUT=1) ALU from
//   the same operands. Directed vectors come from a table; random vectors are
//   compared with an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_riscv_alu;
  import alu_pkg::*;

  typedef struct {
    logic [5:0]  s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        cmp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic [5:0]  s;
  logic [31:0] q_c, q_r;
  logic        cmp_c, cmp_r;

  int n_checks = 0;
  int n_errors = 0;

  riscv_alu #(.WIDTH(32), .REG_OUT(1'b0)) dut_c (
    .clk (clk), .rst_n (rst_n), .A (a), .B (b), .S (s), .Q (q_c), .CMP (cmp_c)
  );

  riscv_alu #(.WIDTH(32), .REG_OUT(1'b1)) dut_r (
    .clk (clk), .rst_n (rst_n), .A (a), .B (b), .S (s), .Q (q_r), .CMP (cmp_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (S=%0d A=%08h B=%08h)",
               name, got, exp, s, a, b);
    end
  endtask

  // Reference model: operands treated as integers, shifts as powers of two.
  function automatic void model(input logic [5:0] sel, input logic [31:0] av,
                                input logic [31:0] bv, output logic [31:0] qv,
                                output logic cmpv);
    longint ua, ub, sa, sb, p2, t;
    ua = longint'({32'd0, av});
    ub = longint'({32'd0, bv});
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    p2 = 1;
    for (int i = 0; i < int'(bv[4:0]); i++) p2 = p2 * 2;
    qv   = '0;
    cmpv = 1'b0;
    if (sel[1:0] == 2'b01) begin
      case ({sel[5], sel[4:2]})
        4'b0000: qv = 32'(ua + ub);
        4'b1000: qv = 32'(ua - ub);
        4'b0001: qv = 32'(ua * p2);
        4'b0010: qv = (sa <= sb) ? 32'd1 : 32'd0;
        4'b0011: qv = (ua <= ub) ? 32'd1 : 32'd0;
        4'b0100: qv = av ^ bv;
        4'b0101: qv = 32'(ua / p2);
        4'b1101: begin
          t = sa / p2;                              // truncates toward zero
          if (sa < 0 && (sa % p2) != 0) t = t - 1;  // floor for negatives
          qv = 32'(t);
        end
        4'b0110: qv = av | bv;
        4'b0111: qv = av & bv;
        default: qv = '0;
      endcase
    end else if (sel[1:0] == 2'b11) begin
      case (sel[4:2])
        3'b000: cmpv = (ua == ub);
        3'b001: cmpv = (ua != ub);
        3'b100: cmpv = (sa <  sb);
        3'b101: cmpv = (sa >= sb);
        3'b110: cmpv = (ua <  ub);
        3'b111: cmpv = (ua >= ub);
        default: cmpv = 1'b0;
      endcase
    end
  endfunction

  // Drive one vector at a falling edge, check the combinational copy, then
  // check the registered copy just after the following rising edge.
  task automatic apply(input string tag, input logic [5:0] sv,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eq_q, input logic eq_cmp);
    @(negedge clk);
    s = sv; a = av; b = bv;
    #1;
    check({tag, " comb Q"},   q_c,   eq_q);
    check({tag, " comb CMP"}, {31'd0, cmp_c}, {31'd0, eq_cmp});
    @(posedge clk);
    #1;
    check({tag, " reg Q"},   q_r,   eq_q);
    check({tag, " reg CMP"}, {31'd0, cmp_r}, {31'd0, eq_cmp});
  endtask

  vec_t        tbl[$];
  logic [31:0] mq;
  logic        mcmp;

  initial begin
    rst_n = 1'b0;
    s = '0; a = '0; b = '0;

    tbl.push_back('{6'd0,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
    tbl.push_back('{S_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
    tbl.push_back('{S_ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
    tbl.push_back('{S_SUB,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0});
    tbl.push_back('{S_SUB,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    tbl.push_back('{S_AND,  32'hF0F0F0F0, 32'h0FF0F00F, 32'h00F0F000, 1'b0});
    tbl.push_back('{S_OR,   32'hF0F0F0F0, 32'h0FF0F00F, 32'hFFF0F0FF, 1'b0});
    tbl.push_back('{S_XOR,  32'hF0F0F0F0, 32'h0FF0F00F, 32'hFF0000FF, 1'b0});
    tbl.push_back('{S_SLL,  32'hF0F0F0F7, 32'd2,        32'hC3C3C3DC, 1'b0});
    tbl.push_back('{S_SRL,  32'hF0F0F0F7, 32'd5,        32'h07878787, 1'b0});
    tbl.push_back('{S_SRA,  32'h00F0F0F7, 32'd4,        32'h000F0F0F, 1'b0});
    tbl.push_back('{S_SRA,  32'hF0F0F0F7, 32'd3,        32'hFE1E1E1E, 1'b0});
    tbl.push_back('{S_SRA,  32'hF0F0F0F7, 32'hFFFFFFE0, 32'hF0F0F0F7, 1'b0});
    tbl.push_back('{S_SLL,  32'h12345678, 32'h00000020, 32'h12345678, 1'b0});
    tbl.push_back('{S_SLT,  -32'sd35,     -32'sd35,     32'd1,        1'b0});
    tbl.push_back('{S_SLT,  32'd100,      -32'sd26,     32'd0,        1'b0});
    tbl.push_back('{S_SLTU, 32'hFFFFFFBF, 32'hFFFFFFBF, 32'd1,        1'b0});
    tbl.push_back('{S_SLTU, 32'd928,      32'd741,      32'd0,        1'b0});
    tbl.push_back('{S_BEQ,  -32'sd27650,  -32'sd27650,  32'd0,        1'b1});
    tbl.push_back('{6'd35,  32'd928,      32'd741,      32'd0,        1'b0});
    tbl.push_back('{6'd39,  -32'sd27650,  32'd0,        32'd0,        1'b1});
    tbl.push_back('{6'd51,  -32'sd48,     32'd2795,     32'd0,        1'b1});
    tbl.push_back('{S_BGEU, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0});
    tbl.push_back('{6'd41,  32'h00000005, 32'h00000003, 32'd0,        1'b0});

    // Reset state: registered outputs stay clear across edges while held.
    #2;
    check("reset Q", q_r, 32'd0);
    check("reset CMP", {31'd0, cmp_r}, 32'd0);
    s = S_ADD; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    check("reset hold Q", q_r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      apply($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].b,
            tbl[i].q, tbl[i].cmp);

    // One-cycle lag: new inputs must not reach the registered Q before the edge.
    apply("lag0", S_ADD, 32'd3, 32'd4, 32'd7, 1'b0);
    @(negedge clk);
    s = S_XOR; a = 32'hAAAA0000; b = 32'h0000AAAA;
    #1;
    check("lag old Q", q_r, 32'd7);
    check("lag new comb Q", q_c, 32'hAAAAAAAA);
    @(posedge clk); #1;
    check("lag new reg Q", q_r, 32'hAAAAAAAA);

    // Mid-stream reset clears both outputs at once and drops the pending result.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 0) begin s = S_ADD; a = 32'd5; b = 32'd6; end
      else        begin s = S_BEQ; a = 32'd9; b = 32'd9; end
      model(s, a, b, mq, mcmp);
      @(posedge clk); #1;
      check("pre-rst Q", q_r, mq);
      check("pre-rst CMP", {31'd0, cmp_r}, {31'd0, mcmp});
      #1 rst_n = 1'b0;
      #1;
      check("async rst Q", q_r, 32'd0);
      check("async rst CMP", {31'd0, cmp_r}, 32'd0);
      @(posedge clk); #1;
      check("rst held Q", q_r, 32'd0);
      check("rst held CMP", {31'd0, cmp_r}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post-rel Q", q_r, 32'd0);
      @(posedge clk); #1;
      check("post-rel cap Q", q_r, mq);
      check("post-rel cap CMP", {31'd0, cmp_r}, {31'd0, mcmp});
    end

    // Random vectors against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  rs;
      logic [31:0] ra, rb;
      rs = 6'($urandom_range(0, 63));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = 32'($urandom_range(0, 40));
        default: rb = $urandom;
      endcase
      model(rs, ra, rb, mq, mcmp);
      apply($sformatf("rand%0d", n), rs, ra, rb, mq, mcmp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
